lcd_write_arbiter: RTL and testbench

- Shares the single LCD transaction layer byte-write port (do_write_data / data_to_write / send_data_done) between N_REQ byte-stream requesters, e.g. the flash-ID display path and a status-message path.
- Grants one requester at a time and locks the grant for a whole packet (up to the req_last byte).
- Sequences each byte through the write handshake, then rotates priority round-robin.
- Sits between the command layer and transaction; runs on the divided clock.

---
 rtl/lcd_arb_pkg.sv | 18 +
 rtl/lcd_write_arbiter_rr_pick.sv | 25 ++
 rtl/lcd_write_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_lcd_write_arbiter.sv | 391 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_arb_pkg.sv
// Shared types and constants for the LCD byte-write arbiter.
package lcd_arb_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_LOAD  = 2'b01,
    ST_WRITE = 2'b10,
    ST_GAP   = 2'b11
  } arb_state_t;

  // Round-robin successor of a requester index, wrapping at n.
  function automatic logic [1:0] next_ptr(input logic [1:0] ptr, input int n);
    return (int'(ptr) + 1 >= n) ? 2'd0 : ptr + 2'd1;
  endfunction

endpackage

// File: rtl/lcd_write_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid requester at or above rr_ptr, wrapping.
module rr_pick #(
  parameter int N_REQ = 2
) (
  input  logic [N_REQ-1:0] req_valid,
  input  logic [1:0]       rr_ptr,
  output logic [N_REQ-1:0] grant
);

  logic found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!found && req_valid[i] && (i == (int'(rr_ptr) + k) % N_REQ)) begin
          grant[i] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/lcd_write_arbiter.sv
// Packet-locked round-robin arbiter in front of the LCD transaction byte-write port.
// Optional watchdog on the write handshake: define LCD_ARB_WDOG_EN (adds err_timeout).
module lcd_write_arbiter
  import lcd_arb_pkg::*;
#(
  parameter int N_REQ     = 2,
  parameter int MAX_BYTES = 32,
  parameter int TIMEOUT   = 4095
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    init_done,
  input  logic                    send_data_done,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [BYTE_W*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]        req_last,
  output logic [N_REQ-1:0]        req_ready,
  output logic [N_REQ-1:0]        grant,
  output logic                    do_write_data,
  output logic [BYTE_W-1:0]       data_to_write,
  output logic                    busy,
  output logic                    err_overrun
`ifdef LCD_ARB_WDOG_EN
  ,
  output logic                    err_timeout
`endif
);

  localparam int CNT_W = $clog2(MAX_BYTES + 1);

  if (N_REQ < 2 || N_REQ > 4 || MAX_BYTES < 1 || TIMEOUT < 1) begin : g_bad_params
    $error("lcd_write_arbiter: unsupported parameter set");
  end

  arb_state_t        state_q, state_d;
  logic [N_REQ-1:0]  grant_q, grant_d, pick;
  logic              busy_q, busy_d;
  logic              do_q, do_d;
  logic              last_q, last_d;
  logic              ovr_q, ovr_d;
  logic [BYTE_W-1:0] data_q, data_d, owner_data;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        rr_q, rr_d, owner;
  logic              owner_valid, owner_last, pkt_end;

`ifdef LCD_ARB_WDOG_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd_q, wd_d;
  logic            tmo_q, tmo_d;
`endif

  rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
    .req_valid (req_valid),
    .rr_ptr    (rr_q),
    .grant     (pick)
  );

  always_comb begin
    owner = 2'd0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_q[i]) owner = 2'(i);
    end
  end

  assign owner_valid = |(grant_q & req_valid);
  assign owner_last  = |(grant_q & req_last);
  assign owner_data  = req_data[BYTE_W*owner +: BYTE_W];
  assign pkt_end     = last_q || (cnt_q == CNT_W'(MAX_BYTES));

  // Only the owner may be handed a byte, and only while a byte slot is open.
  assign req_ready = (state_q == ST_LOAD) ? (grant_q & req_valid) : '0;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    busy_d  = busy_q;
    do_d    = do_q;
    data_d  = data_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    rr_d    = rr_q;
    ovr_d   = ovr_q;
`ifdef LCD_ARB_WDOG_EN
    wd_d    = wd_q;
    tmo_d   = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (init_done && |req_valid) begin
          grant_d = pick;
          busy_d  = 1'b1;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (owner_valid) begin
          data_d  = owner_data;
          last_d  = owner_last;
          cnt_d   = cnt_q + CNT_W'(1);
          do_d    = 1'b1;
          state_d = ST_WRITE;
`ifdef LCD_ARB_WDOG_EN
          wd_d    = '0;
`endif
        end
      end
      ST_WRITE: begin
        if (send_data_done) begin
          do_d    = 1'b0;
          state_d = ST_GAP;
        end
`ifdef LCD_ARB_WDOG_EN
        else if (wd_q == WD_W'(TIMEOUT - 1)) begin
          // Abandon the packet; unsent bytes stay with the requester.
          do_d    = 1'b0;
          grant_d = '0;
          busy_d  = 1'b0;
          rr_d    = next_ptr(owner, N_REQ);
          cnt_d   = '0;
          tmo_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
`endif
      end
      ST_GAP: begin
        if (pkt_end) begin
          grant_d = '0;
          busy_d  = 1'b0;
          rr_d    = next_ptr(owner, N_REQ);
          cnt_d   = '0;
          if (!last_q) ovr_d = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_LOAD;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      busy_q  <= 1'b0;
      do_q    <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
      cnt_q   <= '0;
      rr_q    <= 2'd0;
      ovr_q   <= 1'b0;
`ifdef LCD_ARB_WDOG_EN
      wd_q    <= '0;
      tmo_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
      do_q    <= do_d;
      data_q  <= data_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
      ovr_q   <= ovr_d;
`ifdef LCD_ARB_WDOG_EN
      wd_q    <= wd_d;
      tmo_q   <= tmo_d;
`endif
    end
  end

  assign grant         = grant_q;
  assign busy          = busy_q;
  assign do_write_data = do_q;
  assign data_to_write = data_q;
  assign err_overrun   = ovr_q;
`ifdef LCD_ARB_WDOG_EN
  assign err_timeout   = tmo_q;
`endif

endmodule

// File: tb/tb_lcd_write_arbiter.sv
// Self-checking bench for lcd_write_arbiter (N_REQ=2, MAX_BYTES=32, TIMEOUT=16).
module tb_lcd_write_arbiter;

  localparam int MAXB = 32;
  localparam int TMO  = 16;

  logic        clk;
  logic        reset;
  logic        init_done;
  logic        send_data_done;
  logic [1:0]  req_valid;
  logic [15:0] req_data;
  logic [1:0]  req_last;
  logic [1:0]  req_ready;
  logic [1:0]  grant;
  logic        do_write_data;
  logic [7:0]  data_to_write;
  logic        busy;
  logic        err_overrun;
`ifdef LCD_ARB_WDOG_EN
  logic        err_timeout;
`endif

  lcd_write_arbiter #(.N_REQ(2), .MAX_BYTES(MAXB), .TIMEOUT(TMO)) dut (
    .clk            (clk),
    .reset          (reset),
    .init_done      (init_done),
    .send_data_done (send_data_done),
    .req_valid      (req_valid),
    .req_data       (req_data),
    .req_last       (req_last),
    .req_ready      (req_ready),
    .grant          (grant),
    .do_write_data  (do_write_data),
    .data_to_write  (data_to_write),
    .busy           (busy),
    .err_overrun    (err_overrun)
`ifdef LCD_ARB_WDOG_EN
    ,
    .err_timeout    (err_timeout)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [7:0] data; logic last; } src_t;
  typedef struct { logic [1:0] owner; logic [7:0] data; int pkt; } wr_t;
  typedef struct { logic [7:0] data; logic pkt_end; } exp_t;
  typedef struct {
    logic [1:0] mask; logic [7:0] d0; logic [7:0] d1; int n;
    logic [1:0] g0; logic [1:0] g1; logic [7:0] e0; logic [7:0] e1;
  } vec_t;

  src_t src0[$], src1[$];
  wr_t  wlog[$];
  exp_t exp0[$], exp1[$];
  vec_t tbl[7];

  int   nvec = 0, nfail = 0;
  int   pkt_id = 0;
  logic [1:0] pend = 2'b00, hold = 2'b00;
  logic rsp_en = 1'b1, rnd_mode = 1'b0;
  int   rsp_min = 3, rsp_max = 3;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nvec++;
    if (actual !== expected) begin
      nfail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int r, input logic [7:0] d, input logic last);
    if (r == 0) src0.push_back('{d, last});
    else        src1.push_back('{d, last});
  endtask

  task automatic boundFail(input string name);
    nvec++;
    nfail++;
    $display("[TB] FAIL %s: wait budget expired", name);
  endtask

  task automatic waitIdle(input int budget);
    int c = 0;
    while (c < budget && !(src0.size() == 0 && src1.size() == 0 && !busy && !do_write_data)) begin
      @(negedge clk);
      c++;
    end
    if (c >= budget) boundFail("wait_idle");
  endtask

  task automatic waitWrites(input int n, input int budget);
    int c = 0;
    while (c < budget && wlog.size() < n) begin
      @(negedge clk);
      c++;
    end
    if (c >= budget) boundFail("wait_writes");
  endtask

  // Requester sources: present queue head, pop once a handshake has happened.
  initial begin
    req_valid = '0; req_data = '0; req_last = '0;
    forever begin
      @(negedge clk);
      if (pend[0] && src0.size() > 0) void'(src0.pop_front());
      if (pend[1] && src1.size() > 0) void'(src1.pop_front());
      pend = 2'b00;
      if (src0.size() > 0 && !hold[0]) begin
        req_valid[0] = 1'b1; req_data[7:0] = src0[0].data; req_last[0] = src0[0].last;
      end else begin
        req_valid[0] = 1'b0; req_last[0] = 1'b0;
      end
      if (src1.size() > 0 && !hold[1]) begin
        req_valid[1] = 1'b1; req_data[15:8] = src1[0].data; req_last[1] = src1[0].last;
      end else begin
        req_valid[1] = 1'b0; req_last[1] = 1'b0;
      end
      #1;
      if (!reset) begin
        pend = req_valid & req_ready;
        checkOutput("ready_owner_only", {30'b0, req_ready & ~grant}, 32'd0);
      end
    end
  end

  // Transaction model: acknowledge each write after a delay.
  initial begin
    int hi = 0, dly = 3;
    send_data_done = 1'b0;
    forever begin
      @(negedge clk);
      if (send_data_done) begin
        send_data_done = 1'b0;
        hi = 0;
      end else if (do_write_data && rsp_en) begin
        hi++;
        if (hi >= dly) begin
          send_data_done = 1'b1;
          hi = 0;
          dly = $urandom_range(rsp_max, rsp_min);
        end
      end else if (!do_write_data) begin
        hi = 0;
      end
    end
  end

  // Write monitor: logs every byte handed to the transaction layer with its packet number.
  initial begin
    logic [1:0] pg = '0;
    logic pd = 1'b0;
    forever begin
      @(negedge clk);
      if (grant != 2'b00 && pg == 2'b00) pkt_id++;
      if (do_write_data && !pd) wlog.push_back('{grant, data_to_write, pkt_id});
      pg = grant;
      pd = do_write_data;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rnd_mode) begin
        hold[0] = ($urandom_range(3, 0) == 0);
        hold[1] = ($urandom_range(3, 0) == 0);
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: simulation did not complete");
    $fatal(1, "[TB] global timeout");
  end

  initial begin
    logic [1:0] prev_end;
    int last_pkt[2];
    int seg, len, r, k, hi_cnt, tmo_cnt, c;
    logic exp_ovr, lst, pe;
    logic [7:0] d;
    exp_t e;

    tbl[0] = '{2'b10, 8'h00, 8'h30, 1, 2'b10, 2'b00, 8'h30, 8'h00};
    tbl[1] = '{2'b11, 8'h40, 8'h41, 2, 2'b01, 2'b10, 8'h40, 8'h41};
    tbl[2] = '{2'b01, 8'h50, 8'h00, 1, 2'b01, 2'b00, 8'h50, 8'h00};
    tbl[3] = '{2'b11, 8'h60, 8'h61, 2, 2'b10, 2'b01, 8'h61, 8'h60};
    tbl[4] = '{2'b11, 8'h70, 8'h71, 2, 2'b10, 2'b01, 8'h71, 8'h70};
    tbl[5] = '{2'b10, 8'h00, 8'h80, 1, 2'b10, 2'b00, 8'h80, 8'h00};
    tbl[6] = '{2'b01, 8'h90, 8'h00, 1, 2'b01, 2'b00, 8'h90, 8'h00};

    reset = 1'b1;
    init_done = 1'b0;
    repeat (2) @(negedge clk);
    applyStimulus(0, 8'h43, 1'b0);
    applyStimulus(0, 8'h50, 1'b1);
    reset = 1'b0;

    // init_done low holds the arbiter idle even with a requester waiting
    repeat (4) begin
      @(negedge clk);
      checkOutput("nogrant_before_init", {30'b0, grant}, 32'd0);
      checkOutput("nowrite_before_init", {31'b0, do_write_data}, 32'd0);
    end
    init_done = 1'b1;
    @(negedge clk);
    checkOutput("grant_after_init", {30'b0, grant}, 32'd1);
    checkOutput("busy_after_init", {31'b0, busy}, 32'd1);
    checkOutput("no_write_in_load", {31'b0, do_write_data}, 32'd0);
    @(negedge clk);
    checkOutput("write_latency", {31'b0, do_write_data}, 32'd1);
    checkOutput("first_byte", {24'b0, data_to_write}, 32'h43);
    waitIdle(200);
    checkOutput("cp_count", 32'(wlog.size()), 32'd2);
    if (wlog.size() == 2) begin
      checkOutput("cp_byte1", {24'b0, wlog[1].data}, 32'h50);
      checkOutput("cp_owner", {28'b0, wlog[0].owner, wlog[1].owner}, 32'h5);
      checkOutput("cp_one_packet", 32'(wlog[1].pkt - wlog[0].pkt), 32'd0);
    end
    checkOutput("cp_grant_end", {30'b0, grant}, 32'd0);
    checkOutput("cp_busy_end", {31'b0, busy}, 32'd0);

    // Arbitration table: single-byte packets, rr pointer carried row to row
    for (int v = 0; v < 7; v++) begin
      wlog.delete();
      if (tbl[v].mask[0]) applyStimulus(0, tbl[v].d0, 1'b1);
      if (tbl[v].mask[1]) applyStimulus(1, tbl[v].d1, 1'b1);
      waitIdle(200);
      checkOutput($sformatf("tbl%0d_count", v), 32'(wlog.size()), 32'(tbl[v].n));
      if (wlog.size() >= 1) begin
        checkOutput($sformatf("tbl%0d_g0", v), {30'b0, wlog[0].owner}, {30'b0, tbl[v].g0});
        checkOutput($sformatf("tbl%0d_e0", v), {24'b0, wlog[0].data}, {24'b0, tbl[v].e0});
      end
      if (tbl[v].n == 2 && wlog.size() >= 2) begin
        checkOutput($sformatf("tbl%0d_g1", v), {30'b0, wlog[1].owner}, {30'b0, tbl[v].g1});
        checkOutput($sformatf("tbl%0d_e1", v), {24'b0, wlog[1].data}, {24'b0, tbl[v].e1});
        checkOutput($sformatf("tbl%0d_newpkt", v), {31'b0, wlog[1].pkt != wlog[0].pkt}, 32'd1);
      end
    end

    // Owner stalls mid-packet: grant stays locked, other requester waits
    wlog.delete();
    applyStimulus(1, 8'hA1, 1'b0);
    applyStimulus(1, 8'hA2, 1'b0);
    applyStimulus(1, 8'hA3, 1'b1);
    waitWrites(1, 100);
    hold[1] = 1'b1;
    applyStimulus(0, 8'hB0, 1'b1);
    repeat (9) begin
      @(negedge clk);
      #2;
      checkOutput("stall_grant_held", {30'b0, grant}, 32'd2);
      checkOutput("stall_no_ready0", {31'b0, req_ready[0]}, 32'd0);
    end
    hold[1] = 1'b0;
    waitIdle(300);
    checkOutput("stall_count", 32'(wlog.size()), 32'd4);
    if (wlog.size() == 4) begin
      checkOutput("stall_bytes", {wlog[0].data, wlog[1].data, wlog[2].data, wlog[3].data}, 32'hA1A2A3B0);
      checkOutput("stall_owners", {24'b0, wlog[0].owner, wlog[1].owner, wlog[2].owner, wlog[3].owner}, 32'hA9);
      checkOutput("stall_pkt_locked", 32'(wlog[2].pkt - wlog[0].pkt), 32'd0);
      checkOutput("stall_pkt_next", {31'b0, wlog[3].pkt != wlog[2].pkt}, 32'd1);
    end

    // 33 bytes without last: forced end after byte 32, byte 33 starts a new packet
    checkOutput("ovr_clear_before", {31'b0, err_overrun}, 32'd0);
    wlog.delete();
    for (int b = 0; b < 33; b++) applyStimulus(0, 8'(b + 1), b == 32);
    waitIdle(3000);
    checkOutput("ovr_count", 32'(wlog.size()), 32'd33);
    if (wlog.size() == 33) begin
      c = 0;
      for (int b = 0; b < 33; b++) if (wlog[b].data !== 8'(b + 1) || wlog[b].owner !== 2'b01) c++;
      checkOutput("ovr_bytes_bad", 32'(c), 32'd0);
      checkOutput("ovr_32_one_pkt", 32'(wlog[31].pkt - wlog[0].pkt), 32'd0);
      checkOutput("ovr_33_new_pkt", {31'b0, wlog[32].pkt != wlog[31].pkt}, 32'd1);
    end
    checkOutput("ovr_flag", {31'b0, err_overrun}, 32'd1);

    // Randomized traffic checked against per-requester byte streams and packet segmentation
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    wlog.delete();
    exp_ovr = 1'b0;
    rsp_min = 1; rsp_max = 5;
    for (r = 0; r < 2; r++) begin
      seg = 0;
      for (int p = 0; p < 4; p++) begin
        len = ($urandom_range(3, 0) == 0) ? $urandom_range(40, 30) : $urandom_range(8, 1);
        for (int b = 0; b < len; b++) begin
          d   = 8'($urandom);
          lst = (b == len - 1);
          applyStimulus(r, d, lst);
          seg++;
          pe = lst || (seg == MAXB);
          if (seg == MAXB && !lst) exp_ovr = 1'b1;
          if (pe) seg = 0;
          if (r == 0) exp0.push_back('{d, pe});
          else        exp1.push_back('{d, pe});
        end
      end
    end
    rnd_mode = 1'b1;
    waitIdle(30000);
    rnd_mode = 1'b0;
    hold = 2'b00;
    prev_end = 2'b11;
    last_pkt[0] = -1;
    last_pkt[1] = -1;
    for (k = 0; k < wlog.size(); k++) begin
      checkOutput("rnd_owner_onehot", 32'($countones(wlog[k].owner)), 32'd1);
      r = (wlog[k].owner == 2'b10) ? 1 : 0;
      if ((r == 0 && exp0.size() == 0) || (r == 1 && exp1.size() == 0)) begin
        boundFail("rnd_extra_write");
      end else begin
        e = (r == 0) ? exp0.pop_front() : exp1.pop_front();
        checkOutput("rnd_data", {24'b0, wlog[k].data}, {24'b0, e.data});
        if (prev_end[r]) checkOutput("rnd_new_pkt", {31'b0, wlog[k].pkt != last_pkt[r]}, 32'd1);
        else             checkOutput("rnd_same_pkt", 32'(wlog[k].pkt), 32'(last_pkt[r]));
        prev_end[r] = e.pkt_end;
        last_pkt[r] = wlog[k].pkt;
      end
    end
    checkOutput("rnd_left0", 32'(exp0.size()), 32'd0);
    checkOutput("rnd_left1", 32'(exp1.size()), 32'd0);
    checkOutput("rnd_overrun", {31'b0, err_overrun}, {31'b0, exp_ovr});
    rsp_min = 3; rsp_max = 3;

`ifdef LCD_ARB_WDOG_EN
    // Withheld acknowledge: write held TIMEOUT cycles, then one-cycle err_timeout and abort
    wlog.delete();
    rsp_en = 1'b0;
    applyStimulus(0, 8'hE1, 1'b0);
    applyStimulus(0, 8'hE2, 1'b1);
    waitWrites(1, 100);
    hi_cnt = 0; tmo_cnt = 0;
    for (int t = 0; t < 40; t++) begin
      if (do_write_data) hi_cnt++;
      if (err_timeout) begin
        tmo_cnt++;
        checkOutput("wd_grant_cleared", {30'b0, grant}, 32'd0);
      end
      @(negedge clk);
    end
    checkOutput("wd_write_cycles", 32'(hi_cnt), 32'(TMO));
    checkOutput("wd_pulse_count", 32'(tmo_cnt), 32'd1);
    rsp_en = 1'b1;
    waitIdle(300);
    checkOutput("wd_count", 32'(wlog.size()), 32'd2);
    if (wlog.size() == 2) begin
      checkOutput("wd_bytes", {16'b0, wlog[0].data, wlog[1].data}, 32'hE1E2);
      checkOutput("wd_new_pkt", {31'b0, wlog[1].pkt != wlog[0].pkt}, 32'd1);
    end
`endif

    // Reset mid-write drops everything immediately
    rsp_en = 1'b0;
    applyStimulus(0, 8'h77, 1'b1);
    c = 0;
    while (c < 100 && !do_write_data) begin
      @(negedge clk);
      c++;
    end
    if (c >= 100) boundFail("wait_write_for_reset");
    #2;
    reset = 1'b1;
    #1;
    checkOutput("rst_do_write", {31'b0, do_write_data}, 32'd0);
    checkOutput("rst_grant", {30'b0, grant}, 32'd0);
    checkOutput("rst_busy", {31'b0, busy}, 32'd0);
    checkOutput("rst_data", {24'b0, data_to_write}, 32'd0);
    checkOutput("rst_overrun", {31'b0, err_overrun}, 32'd0);
    checkOutput("rst_ready", {30'b0, req_ready}, 32'd0);
    src0.delete();
    src1.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    rsp_en = 1'b1;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
